// File: rtl/frame_ind_pkg.sv
// Shared types and default widths for the multi-window frame indication generator.
package frame_ind_pkg;

    localparam int ROW_W_DEF   = 10;
    localparam int COL_W_DEF   = 11;
    localparam int NUM_ROI_DEF = 2;

    // Shadowed bounds are held at this width so one struct serves any ROW_W/COL_W up to 16.
    localparam int BOUND_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [BOUND_W-1:0] rs;
        logic [BOUND_W-1:0] re;
        logic [BOUND_W-1:0] cs;
        logic [BOUND_W-1:0] ce;
        logic               en;
    } roi_cfg_t;

endpackage

// File: rtl/roi_match.sv
// Inclusive row/column window compare for one ROI; purely combinational.
module roi_match
    import frame_ind_pkg::*;
#(
    parameter int ROW_W = ROW_W_DEF,
    parameter int COL_W = COL_W_DEF
) (
    input  roi_cfg_t         cfg_i,
    input  logic             eligible_i,
    input  logic [ROW_W-1:0] cnt_line_i,
    input  logic [COL_W-1:0] cnt_pixel_i,
    output logic             hit_o,
    output logic             line_begin_o,
    output logic             line_end_o
);

    logic [BOUND_W-1:0] line_w;
    logic [BOUND_W-1:0] pix_w;
    logic               in_rows;
    logic               in_cols;

    assign line_w = BOUND_W'(cnt_line_i);
    assign pix_w  = BOUND_W'(cnt_pixel_i);

    // A window whose start exceeds its end can never satisfy both compares.
    assign in_rows = (line_w >= cfg_i.rs) && (line_w <= cfg_i.re);
    assign in_cols = (pix_w >= cfg_i.cs) && (pix_w <= cfg_i.ce);

    assign hit_o        = eligible_i & cfg_i.en & in_rows & in_cols;
    assign line_begin_o = hit_o & (pix_w == cfg_i.cs);
    assign line_end_o   = hit_o & (pix_w == cfg_i.ce);

endmodule

// File: rtl/multi_roi_frame_gen.sv
// Converts sensor FV/LV strobes into frame/line events, pixel/line coordinates,
// per-window ROI strobes, frame decimation, frame counting and sticky error flags.
// ROW_W and COL_W must not exceed frame_ind_pkg::BOUND_W.
module multi_roi_frame_gen
    import frame_ind_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int COL_W   = COL_W_DEF,
    parameter int NUM_ROI = NUM_ROI_DEF
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     sensor_state_i,
    input  logic                     sensor_fv_i,
    input  logic                     sensor_lv_i,
    input  logic [NUM_ROI*ROW_W-1:0] roi_row_start_i,
    input  logic [NUM_ROI*ROW_W-1:0] roi_row_end_i,
    input  logic [NUM_ROI*COL_W-1:0] roi_col_start_i,
    input  logic [NUM_ROI*COL_W-1:0] roi_col_end_i,
    input  logic [NUM_ROI-1:0]       roi_enable_i,
    input  logic [3:0]               frame_skip_i,
    input  logic                     err_clear_i,
    output logic                     frame_begin_o,
    output logic                     frame_end_o,
    output logic                     frame_abort_o,
    output logic                     frame_state_o,
    output logic                     frame_keep_o,
    output logic [ROW_W-1:0]         cnt_line_o,
    output logic [COL_W-1:0]         cnt_pixel_o,
    output logic [NUM_ROI-1:0]       roi_hit_o,
    output logic [NUM_ROI-1:0]       roi_line_begin_o,
    output logic [NUM_ROI-1:0]       roi_line_end_o,
    output logic [15:0]              frame_cnt_o,
    output logic [COL_W:0]           line_len_o,
    output logic                     err_lv_no_fv_o,
    output logic                     err_line_len_o
);

    localparam logic [ROW_W-1:0] LINE_MAX = '1;
    localparam logic [COL_W:0]   LEN_MAX  = '1;

    frame_state_e     state_q, state_d;
    logic             fv_q, lv_q;
    logic [ROW_W-1:0] line_q, line_d;
    logic [COL_W:0]   len_q, len_d;
    logic [COL_W:0]   line_len_q, line_len_d;
    logic [COL_W:0]   cur_idx;
    logic             keep_q, keep_d;
    logic [3:0]       skip_q, skip_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             err_lv_q, err_lv_d;
    logic             err_len_q, err_len_d;

    logic             in_frame, fb, fe, le;
    logic             line_start, pixel_valid, roi_eligible;

    roi_cfg_t         cfg_in [NUM_ROI];
    roi_cfg_t         cfg_q  [NUM_ROI];

    assign in_frame = (state_q == FRAME);
    assign fb       = sensor_fv_i & ~fv_q & sensor_state_i;
    assign fe       = ~sensor_fv_i & fv_q & in_frame;
    assign le       = ~sensor_lv_i & lv_q & in_frame;

    // A pixel counts when inside a frame, or on the fb cycle itself so that an LV
    // edge coinciding with fb lands on pixel 0 of line 0.
    assign line_start  = sensor_lv_i & ~lv_q;
    assign pixel_valid = sensor_lv_i & (in_frame | fb);
    assign cur_idx     = line_start ? '0 : len_q;

    // len_q is one bit wider than the pixel index so a full-width line length is representable.
    assign cnt_pixel_o = !pixel_valid    ? '0 :
                         cur_idx[COL_W]  ? '1 : cur_idx[COL_W-1:0];

    assign frame_begin_o  = fb;
    assign frame_state_o  = in_frame;
    assign frame_keep_o   = keep_q;
    assign cnt_line_o     = line_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign line_len_o     = line_len_q;
    assign err_lv_no_fv_o = err_lv_q;
    assign err_line_len_o = err_len_q;

    // Shadows load only on fb, so ROI output is gated off during that cycle by in_frame.
    assign roi_eligible = in_frame & keep_q & sensor_lv_i;

    for (genvar k = 0; k < NUM_ROI; k++) begin : g_roi
        assign cfg_in[k] = '{
            rs: BOUND_W'(roi_row_start_i[k*ROW_W +: ROW_W]),
            re: BOUND_W'(roi_row_end_i[k*ROW_W +: ROW_W]),
            cs: BOUND_W'(roi_col_start_i[k*COL_W +: COL_W]),
            ce: BOUND_W'(roi_col_end_i[k*COL_W +: COL_W]),
            en: roi_enable_i[k]
        };

        roi_match #(
            .ROW_W (ROW_W),
            .COL_W (COL_W)
        ) u_match (
            .cfg_i        (cfg_q[k]),
            .eligible_i   (roi_eligible),
            .cnt_line_i   (line_q),
            .cnt_pixel_i  (cnt_pixel_o),
            .hit_o        (roi_hit_o[k]),
            .line_begin_o (roi_line_begin_o[k]),
            .line_end_o   (roi_line_end_o[k])
        );
    end

    // Frame FSM next state; abort wins over a coincident frame end.
    always_comb begin
        state_d       = state_q;
        frame_end_o   = 1'b0;
        frame_abort_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (fb) state_d = FRAME;
            end
            FRAME: begin
                if (!sensor_state_i) begin
                    state_d       = IDLE;
                    frame_abort_o = 1'b1;
                end else if (fe) begin
                    state_d     = IDLE;
                    frame_end_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, decimation and sticky error next-state.
    always_comb begin
        len_d = '0;
        if (pixel_valid && !frame_abort_o) begin
            len_d = (cur_idx == LEN_MAX) ? LEN_MAX : cur_idx + 1'b1;
        end

        line_d = line_q;
        if (fb || fe || frame_abort_o) begin
            line_d = '0;
        end else if (le && (line_q != LINE_MAX)) begin
            line_d = line_q + 1'b1;
        end

        line_len_d = le ? len_q : line_len_q;

        keep_d      = keep_q;
        skip_d      = skip_q;
        frame_cnt_d = frame_cnt_q;
        if (fb) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            // skip_d loaded from frame_skip_i here doubles as its frame-boundary shadow.
            if (skip_q == 4'd0) begin
                keep_d = 1'b1;
                skip_d = frame_skip_i;
            end else begin
                keep_d = 1'b0;
                skip_d = skip_q - 4'd1;
            end
        end

        err_lv_d  = (sensor_lv_i & ~in_frame & ~fb) | (err_lv_q & ~err_clear_i);
        err_len_d = (le & (line_q != '0) & (len_q != line_len_q)) | (err_len_q & ~err_clear_i);
    end

    // FV history is sampled through reset so a frame already running at reset release
    // cannot produce a spurious frame_begin; a fresh rising edge is required.
    always_ff @(posedge clock_i) begin
        fv_q <= sensor_fv_i;
    end

    // State, counters and flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            lv_q        <= 1'b0;
            line_q      <= '0;
            len_q       <= '0;
            line_len_q  <= '0;
            keep_q      <= 1'b0;
            skip_q      <= 4'd0;
            frame_cnt_q <= 16'd0;
            err_lv_q    <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lv_q        <= sensor_lv_i;
            line_q      <= line_d;
            len_q       <= len_d;
            line_len_q  <= line_len_d;
            keep_q      <= keep_d;
            skip_q      <= skip_d;
            frame_cnt_q <= frame_cnt_d;
            err_lv_q    <= err_lv_d;
            err_len_q   <= err_len_d;
        end
    end

    // ROI shadow registers, captured on frame begin only.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_ROI; k++) cfg_q[k] <= '0;
        end else if (fb) begin
            for (int k = 0; k < NUM_ROI; k++) cfg_q[k] <= cfg_in[k];
        end
    end

endmodule

// File: tb/tb_multi_roi_frame_gen.sv
// Directed bench: a vector table for one full ROI frame plus hand-written sequences
// for decimation, shadowing, line-length error, LV-without-FV and abort/reset.
module tb_multi_roi_frame_gen;

    localparam int ROW_W = 10;
    localparam int COL_W = 11;
    localparam int NR    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              sensor_state = 1'b1;
    logic              sensor_fv = 1'b0;
    logic              sensor_lv = 1'b0;
    logic [NR*ROW_W-1:0] roi_row_start = '0;
    logic [NR*ROW_W-1:0] roi_row_end   = '0;
    logic [NR*COL_W-1:0] roi_col_start = '0;
    logic [NR*COL_W-1:0] roi_col_end   = '0;
    logic [NR-1:0]     roi_enable = '0;
    logic [3:0]        frame_skip = '0;
    logic              err_clear = 1'b0;

    logic              frame_begin, frame_end, frame_abort, frame_state, frame_keep;
    logic [ROW_W-1:0]  cnt_line;
    logic [COL_W-1:0]  cnt_pixel;
    logic [NR-1:0]     roi_hit, roi_line_begin, roi_line_end;
    logic [15:0]       frame_cnt;
    logic [COL_W:0]    line_len;
    logic              err_lv_no_fv, err_line_len;

    multi_roi_frame_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .NUM_ROI(NR)) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .sensor_state_i   (sensor_state),
        .sensor_fv_i      (sensor_fv),
        .sensor_lv_i      (sensor_lv),
        .roi_row_start_i  (roi_row_start),
        .roi_row_end_i    (roi_row_end),
        .roi_col_start_i  (roi_col_start),
        .roi_col_end_i    (roi_col_end),
        .roi_enable_i     (roi_enable),
        .frame_skip_i     (frame_skip),
        .err_clear_i      (err_clear),
        .frame_begin_o    (frame_begin),
        .frame_end_o      (frame_end),
        .frame_abort_o    (frame_abort),
        .frame_state_o    (frame_state),
        .frame_keep_o     (frame_keep),
        .cnt_line_o       (cnt_line),
        .cnt_pixel_o      (cnt_pixel),
        .roi_hit_o        (roi_hit),
        .roi_line_begin_o (roi_line_begin),
        .roi_line_end_o   (roi_line_end),
        .frame_cnt_o      (frame_cnt),
        .line_len_o       (line_len),
        .err_lv_no_fv_o   (err_lv_no_fv),
        .err_line_len_o   (err_line_len)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       fv, lv;
        logic       e_fb, e_fe, e_fs;
        int         e_line, e_pix;
        logic [1:0] e_hit, e_lb, e_le;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One bus cycle: inputs change 1 after the edge, outputs are checked 2 after it.
    task automatic cyc(input logic fv, input logic lv, input logic st, input logic clr);
        @(posedge clock);
        #1;
        sensor_fv    = fv;
        sensor_lv    = lv;
        sensor_state = st;
        err_clear    = clr;
        #1;
    endtask

    task automatic cy(input logic fv, input logic lv);
        cyc(fv, lv, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        sensor_fv = 1'b0; sensor_lv = 1'b0; sensor_state = 1'b1; err_clear = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        #1;
    endtask

    task automatic set_roi(input int k, input int rs, input int re, input int cs, input int ce, input logic en);
        roi_row_start[k*ROW_W +: ROW_W] = ROW_W'(rs);
        roi_row_end[k*ROW_W +: ROW_W]   = ROW_W'(re);
        roi_col_start[k*COL_W +: COL_W] = COL_W'(cs);
        roi_col_end[k*COL_W +: COL_W]   = COL_W'(ce);
        roi_enable[k]                   = en;
    endtask

    task automatic add(input logic fv, input logic lv, input logic fb, input logic fe, input logic fs,
                       input int line, input int pix, input logic [1:0] hit, input logic [1:0] lb,
                       input logic [1:0] le);
        vec_t v;
        v.fv = fv; v.lv = lv; v.e_fb = fb; v.e_fe = fe; v.e_fs = fs;
        v.e_line = line; v.e_pix = pix; v.e_hit = hit; v.e_lb = lb; v.e_le = le;
        vecs.push_back(v);
    endtask

    // 4 lines x 8 pixels with 2-cycle line gaps; counts roi_hit[0] cycles.
    task automatic run_frame(input int chg_line, input logic [COL_W-1:0] chg_ce,
                             output logic keep, output int hits);
        hits = 0;
        cy(1, 0);
        cy(1, 0);
        keep = frame_keep;
        for (int l = 0; l < 4; l++) begin
            if (l == chg_line) roi_col_end[COL_W-1:0] = chg_ce;
            for (int p = 0; p < 8; p++) begin
                cy(1, 1);
                if (roi_hit[0]) hits++;
            end
            cy(1, 0);
            cy(1, 0);
        end
        cy(0, 0);
        cy(0, 0);
    endtask

    task automatic drive_line(input int n);
        for (int p = 0; p < n; p++) cy(1, 1);
        cy(1, 0);
    endtask

    initial begin
        logic       keep;
        int         hits;
        logic [5:0] exp_keep;
        logic       h;

        // ---------------- table: one 4x8 frame, ROI0 rows 1..2 cols 2..5, ROI1 disabled
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add(1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00);
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 8; p++) begin
                h = (l >= 1) && (l <= 2) && (p >= 2) && (p <= 5);
                add(1, 1, 0, 0, 1, l, p, {1'b0, h}, {1'b0, h && (p == 2)}, {1'b0, h && (p == 5)});
            end
            add(1, 0, 0, 0, 1, l, 0, 2'b00, 2'b00, 2'b00);
            add(1, 0, 0, 0, 1, l + 1, 0, 2'b00, 2'b00, 2'b00);
        end
        add(0, 0, 0, 1, 1, 4, 0, 2'b00, 2'b00, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

        set_roi(0, 1, 2, 2, 5, 1'b1);
        set_roi(1, 0, 3, 0, 7, 1'b0);
        frame_skip = 4'd0;
        do_reset();

        chk("rst frame_state", 32'(frame_state), 0);
        chk("rst frame_keep", 32'(frame_keep), 0);
        chk("rst cnt_line", 32'(cnt_line), 0);
        chk("rst cnt_pixel", 32'(cnt_pixel), 0);
        chk("rst frame_cnt", 32'(frame_cnt), 0);
        chk("rst line_len", 32'(line_len), 0);
        chk("rst err_lv_no_fv", 32'(err_lv_no_fv), 0);
        chk("rst err_line_len", 32'(err_line_len), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cy(vecs[i].fv, vecs[i].lv);
            chk($sformatf("t1[%0d] frame_begin", i), 32'(frame_begin), 32'(vecs[i].e_fb));
            chk($sformatf("t1[%0d] frame_end", i), 32'(frame_end), 32'(vecs[i].e_fe));
            chk($sformatf("t1[%0d] frame_state", i), 32'(frame_state), 32'(vecs[i].e_fs));
            chk($sformatf("t1[%0d] cnt_line", i), 32'(cnt_line), 32'(vecs[i].e_line));
            chk($sformatf("t1[%0d] cnt_pixel", i), 32'(cnt_pixel), 32'(vecs[i].e_pix));
            chk($sformatf("t1[%0d] roi_hit", i), 32'(roi_hit), 32'(vecs[i].e_hit));
            chk($sformatf("t1[%0d] roi_line_begin", i), 32'(roi_line_begin), 32'(vecs[i].e_lb));
            chk($sformatf("t1[%0d] roi_line_end", i), 32'(roi_line_end), 32'(vecs[i].e_le));
        end
        chk("t1 line_len", 32'(line_len), 8);
        chk("t1 frame_cnt", 32'(frame_cnt), 1);
        chk("t1 err_line_len", 32'(err_line_len), 0);

        // ---------------- decimation: frame_skip = 2 over 6 frames
        frame_skip = 4'd2;
        do_reset();
        exp_keep = 6'b001001;
        for (int f = 0; f < 6; f++) begin
            run_frame(-1, '0, keep, hits);
            chk($sformatf("t2 frame%0d keep", f), 32'(keep), 32'(exp_keep[f]));
            chk($sformatf("t2 frame%0d hits", f), 32'(hits), exp_keep[f] ? 8 : 0);
        end
        chk("t2 frame_cnt", 32'(frame_cnt), 6);

        // ---------------- shadowing: col_end 5 -> 3 changed mid-frame
        frame_skip = 4'd0;
        set_roi(0, 1, 2, 2, 5, 1'b1);
        do_reset();
        run_frame(1, COL_W'(3), keep, hits);
        chk("t3 old bounds hits", 32'(hits), 8);
        run_frame(-1, '0, keep, hits);
        chk("t3 new bounds hits", 32'(hits), 4);

        // ---------------- line-length error: lines 8, 8, 7, 8
        set_roi(0, 1, 2, 2, 5, 1'b1);
        do_reset();
        cy(1, 0);
        cy(1, 0);
        drive_line(8);
        cy(1, 0);
        drive_line(8);
        cy(1, 0);
        chk("t4 err after equal line", 32'(err_line_len), 0);
        drive_line(7);
        chk("t4 err in short le cycle", 32'(err_line_len), 0);
        cy(1, 0);
        chk("t4 err after short line", 32'(err_line_len), 1);
        chk("t4 line_len short", 32'(line_len), 7);
        cyc(1, 0, 1'b1, 1'b1);
        chk("t4 err during clear", 32'(err_line_len), 1);
        cy(1, 0);
        chk("t4 err after clear", 32'(err_line_len), 0);
        drive_line(8);
        cy(1, 0);
        chk("t4 err 8 vs 7", 32'(err_line_len), 1);
        cy(0, 0);
        cy(0, 0);

        // ---------------- LV pulse with FV low
        do_reset();
        cy(0, 1);
        chk("t5 cnt_pixel lv1", 32'(cnt_pixel), 0);
        chk("t5 frame_state", 32'(frame_state), 0);
        chk("t5 err not yet", 32'(err_lv_no_fv), 0);
        cy(0, 1);
        chk("t5 cnt_pixel lv2", 32'(cnt_pixel), 0);
        chk("t5 err set", 32'(err_lv_no_fv), 1);
        cy(0, 0);
        chk("t5 err sticky", 32'(err_lv_no_fv), 1);
        chk("t5 no frame_begin", 32'(frame_begin), 0);
        cyc(0, 0, 1'b1, 1'b1);
        cy(0, 0);
        chk("t5 err cleared", 32'(err_lv_no_fv), 0);

        // ---------------- fb with lb, then abort mid-line, then reset mid-frame
        set_roi(0, 0, 3, 0, 7, 1'b1);
        do_reset();
        cy(1, 1);
        chk("t6 fb frame_begin", 32'(frame_begin), 1);
        chk("t6 fb cnt_pixel", 32'(cnt_pixel), 0);
        chk("t6 fb cnt_line", 32'(cnt_line), 0);
        chk("t6 fb roi_hit suppressed", 32'(roi_hit), 0);
        chk("t6 fb err_lv_no_fv", 32'(err_lv_no_fv), 0);
        cy(1, 1);
        chk("t6 p1 cnt_pixel", 32'(cnt_pixel), 1);
        chk("t6 p1 roi_hit", 32'(roi_hit), 1);
        chk("t6 p1 frame_state", 32'(frame_state), 1);
        cy(1, 1);
        cy(1, 1);
        cy(1, 0);
        cy(1, 0);
        chk("t6 line_len", 32'(line_len), 4);
        chk("t6 cnt_line", 32'(cnt_line), 1);
        cy(1, 1);
        cy(1, 1);
        cyc(1, 1, 1'b0, 1'b0);
        chk("t6 abort pulse", 32'(frame_abort), 1);
        chk("t6 abort no frame_end", 32'(frame_end), 0);
        chk("t6 abort cnt_pixel", 32'(cnt_pixel), 2);
        chk("t6 abort cnt_line", 32'(cnt_line), 1);
        cyc(1, 0, 1'b0, 1'b0);
        chk("t6 post abort pulse", 32'(frame_abort), 0);
        chk("t6 post frame_state", 32'(frame_state), 0);
        chk("t6 post cnt_line", 32'(cnt_line), 0);
        chk("t6 post cnt_pixel", 32'(cnt_pixel), 0);
        chk("t6 post frame_end", 32'(frame_end), 0);
        cy(1, 0);
        chk("t6 no fb without edge", 32'(frame_begin), 0);
        cy(0, 0);
        chk("t6 no fe in idle", 32'(frame_end), 0);
        cy(1, 0);
        chk("t6 fresh fb", 32'(frame_begin), 1);
        cy(1, 0);
        chk("t6 frame_state again", 32'(frame_state), 1);
        chk("t6 frame_cnt", 32'(frame_cnt), 2);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        #1;
        chk("t6 reset frame_state", 32'(frame_state), 0);
        chk("t6 reset no fb", 32'(frame_begin), 0);
        cy(1, 0);
        chk("t6 reset still no fb", 32'(frame_begin), 0);
        chk("t6 reset frame_cnt", 32'(frame_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
